// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with the sign correction and result selection applied in FIX.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [2*XLEN:0]   acc;
  logic [XLEN-1:0]   opm;
  logic [2:0]        f3;
  logic              a_neg, b_neg, b_zero;

  logic              ready, accept, fast_op, a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] fast_prod, prod;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN:0]   step;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign ready   = (state == IDLE) || (state == DONE);
  assign accept  = ready && start_i && !flush_i;
  assign fast_op = FAST_MUL && !funct3_i[2];
  assign busy_o  = (state == CALC) || (state == FIX);
  assign done_o  = (state == DONE);

  always_comb begin
    a_sgn = funct3_i inside {3'b001, 3'b010, 3'b100, 3'b110};
    b_sgn = funct3_i inside {3'b001, 3'b100, 3'b110};
    a_mag = (a_sgn && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
    b_mag = (b_sgn && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;
    fast_prod = '0;
    if (FAST_MUL) fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  end

  // acc holds {hi, lo}: product/multiplier for MUL*, remainder/dividend-quotient for DIV*.
  always_comb begin
    mul_sum  = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, opm} : '0);
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, opm};
    if (!f3[2])             step = {1'b0, mul_sum, acc[XLEN-1:1]};
    else if (div_diff[XLEN]) step = {div_sh, acc[XLEN-2:0], 1'b0};
    else                     step = {div_diff, acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod = acc[2*XLEN-1:0];
    if (a_neg ^ b_neg) prod = -prod;
    quo = acc[XLEN-1:0];
    rem = acc[2*XLEN-1:XLEN];
    case (f3)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = b_zero ? '1 : ((a_neg ^ b_neg) ? -quo : quo);
      default:                fix_res = a_neg ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (fast_op ? FIX : CALC) : IDLE;
      CALC:       if (count == CW'(1)) state_nxt = FIX;
      FIX:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      acc      <= '0;
      opm      <= '0;
      f3       <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_zero   <= 1'b0;
      result_o <= '0;
    end else begin
      if (accept) begin
        f3     <= funct3_i;
        a_neg  <= a_sgn && op_a_i[XLEN-1];
        b_neg  <= b_sgn && op_b_i[XLEN-1];
        b_zero <= (op_b_i == '0);
        count  <= CW'(XLEN);
        if (fast_op) begin
          acc <= {1'b0, fast_prod};
          opm <= '0;
        end else if (funct3_i[2]) begin
          acc <= {{(XLEN+1){1'b0}}, a_mag};
          opm <= b_mag;
        end else begin
          acc <= {{(XLEN+1){1'b0}}, b_mag};
          opm <= a_mag;
        end
      end else if (state == CALC && !flush_i) begin
        acc   <= step;
        count <= count - 1'b1;
      end
      if (state == FIX && !flush_i) result_o <= fix_res;
    end
  end

endmodule
